lsf_spy_readout: RTL and testbench
==================================

LSF_SPY_READOUT -- requirements
Module: lsf_spy_readout

Interface
REQ-001 Parameter LSF_SB_MEM_WIDTH, default 10: spy read address width; spy depth is 2^LSF_SB_MEM_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default HEG2SFHIT_LEN: width of one spy word.
REQ-003 Parameter FREEZE_SETTLE, default 4: cycles between freeze assertion and the first spy read.
REQ-004 Ports: one clock; reset is asynchronous and active-high.
- clock  input  1  main TP clock, nominally 200 MHz
- reset  input  1  asynchronous, active-high
REQ-005 Control ports:
- i_start  input  1  one-cycle pulse that starts a readout
- i_abort  input  1  terminates a readout in progress
- i_start_addr  input  LSF_SB_MEM_WIDTH  first spy address read
- i_num_words  input  LSF_SB_MEM_WIDTH+1  word count; 0 means 2^LSF_SB_MEM_WIDTH
REQ-006 Spy-side ports:
- sb_lsf_mdt_hits_freeze  output  1  freezes spy memory
- sb_lsf_mdt_hits_re  output  1  spy read strobe
- sb_lsf_mdt_hits_raddr  output  LSF_SB_MEM_WIDTH  spy read address
- sb_lsf_mdt_hits_rdata  input  DATA_WIDTH  spy data, valid exactly 1 cycle after re
REQ-007 Stream and status ports:
- o_data  output  DATA_WIDTH  word
- o_valid  output  1  word valid
- i_ready  input  1  consumer accept
- o_last  output  1  final word of the readout
- o_busy  output  1  readout active
- o_done  output  1  one-cycle pulse at completion or abort

Function
REQ-008 States: IDLE, SETTLE, READ, CAPTURE, OUTPUT, RELEASE.
REQ-009 In IDLE, i_start shall latch i_start_addr into addr_q and the resolved count into remaining_q, then move to SETTLE; i_start outside IDLE shall be ignored.
REQ-010 sb_lsf_mdt_hits_freeze shall assert on the cycle after i_start is accepted and shall stay high through RELEASE.
REQ-011 SETTLE shall last exactly FREEZE_SETTLE cycles, then go to READ.
REQ-012 READ shall last one cycle: re=1 and raddr=addr_q, then go to CAPTURE.
REQ-013 CAPTURE shall register sb_lsf_mdt_hits_rdata into o_data, set o_valid=1, set o_last=1 when remaining_q==1, and go to OUTPUT.
REQ-014 In OUTPUT, o_data, o_valid and o_last shall hold while i_ready=0.
REQ-015 On o_valid&&i_ready, o_valid shall deassert next cycle, addr_q shall increment modulo 2^LSF_SB_MEM_WIDTH (1023 wraps to 0), and remaining_q shall decrement; the block then goes to READ if remaining_q was >1, else to RELEASE.
REQ-016 RELEASE shall last one cycle: freeze deasserts and o_done pulses on that cycle; the next state is IDLE.
REQ-017 o_busy shall be 1 in every state except IDLE.
REQ-018 sb_lsf_mdt_hits_re shall never assert outside READ; at most one spy read shall be outstanding.
REQ-019 i_abort in any non-IDLE state shall force RELEASE on the next cycle, clear o_valid and o_last, and produce no further reads; abort has priority over a handshake in the same cycle, and that word counts as not delivered.
REQ-020 i_abort in IDLE shall have no effect; simultaneous i_start and i_abort in IDLE shall start the readout.
REQ-021 Minimum per-word period shall be 3 cycles (READ, CAPTURE, OUTPUT with i_ready=1).

Reset
REQ-022 Asserting reset shall immediately force IDLE and drive freeze=0, re=0, raddr=0, o_data=0, o_valid=0, o_last=0, o_busy=0, o_done=0.
REQ-023 Reset asserted mid-readout shall drop freeze without an o_done pulse; after release the block shall accept a new i_start normally.

Verification
REQ-024 start_addr=5, num_words=3, i_ready=1 -> reads 5,6,7; o_last only on word 3; o_done one cycle after the last handshake; freeze high from start+1 through RELEASE.
REQ-025 start_addr=1022, num_words=4 -> raddr sequence 1022,1023,0,1.
REQ-026 num_words=0 -> exactly 1024 words delivered, then o_done.
REQ-027 i_ready held 0 for 10 cycles on word 2 -> o_data stable, no extra re, no word lost or duplicated.
REQ-028 i_abort during word 2 of 8 -> o_valid drops next cycle, one o_done, freeze released, re silent afterwards.
REQ-029 reset pulse in SETTLE -> all outputs zero immediately; a following start of 2 words completes normally.

Source files
------------

// File: rtl/lsf_spy_readout_if.sv
// Spy-memory read port and output word stream shared by the spy readout block.
// The master modport is the readout engine; the slave modport is the spy memory plus consumer.
interface lsf_spy_readout_if #(
  parameter int LSF_SB_MEM_WIDTH = 10,
  parameter int DATA_WIDTH       = 42
);
  logic                        sb_lsf_mdt_hits_freeze;
  logic                        sb_lsf_mdt_hits_re;
  logic [LSF_SB_MEM_WIDTH-1:0] sb_lsf_mdt_hits_raddr;
  logic [DATA_WIDTH-1:0]       sb_lsf_mdt_hits_rdata;
  logic [DATA_WIDTH-1:0]       o_data;
  logic                        o_valid;
  logic                        i_ready;
  logic                        o_last;

  modport master (
    output sb_lsf_mdt_hits_freeze,
    output sb_lsf_mdt_hits_re,
    output sb_lsf_mdt_hits_raddr,
    input  sb_lsf_mdt_hits_rdata,
    output o_data,
    output o_valid,
    input  i_ready,
    output o_last
  );

  modport slave (
    input  sb_lsf_mdt_hits_freeze,
    input  sb_lsf_mdt_hits_re,
    input  sb_lsf_mdt_hits_raddr,
    output sb_lsf_mdt_hits_rdata,
    input  o_data,
    input  o_valid,
    output i_ready,
    input  o_last
  );
endinterface

// File: rtl/lsf_spy_readout.sv
// Freezes the LSF MDT-hit spy memory, reads a window of words one at a time and streams
// them out with valid/ready, then releases the freeze and pulses done.
module lsf_spy_readout #(
  parameter int LSF_SB_MEM_WIDTH = 10,
  parameter int DATA_WIDTH       = 42,  // HEG2SFHIT_LEN
  parameter int FREEZE_SETTLE    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [LSF_SB_MEM_WIDTH-1:0] i_start_addr,
  input  logic [LSF_SB_MEM_WIDTH:0]   i_num_words,
  lsf_spy_readout_if.master           bus,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int AW    = LSF_SB_MEM_WIDTH;
  localparam int CNT_W = LSF_SB_MEM_WIDTH + 1;
  localparam int DEPTH = 1 << LSF_SB_MEM_WIDTH;
  localparam int SW    = (FREEZE_SETTLE > 1) ? $clog2(FREEZE_SETTLE) : 1;

  typedef enum logic [2:0] {
    IDLE, SETTLE, READ, CAPTURE, OUTPUT, RELEASE
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    addr_q;
  logic [CNT_W-1:0] remaining_q;
  logic [SW-1:0]    settle_q;
  logic             go_release;

  // Abort wins over a same-cycle handshake, so the word on the bus is dropped undelivered.
  always_comb begin
    go_release = 1'b0;
    case (state_q)
      SETTLE, READ, CAPTURE: go_release = i_abort;
      OUTPUT:                go_release = i_abort || (i_ready_hs() && remaining_q <= CNT_W'(1));
      default:               go_release = 1'b0;
    endcase
  end

  function automatic logic i_ready_hs();
    return bus.o_valid && bus.i_ready;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q                    <= IDLE;
      addr_q                     <= '0;
      remaining_q                <= '0;
      settle_q                   <= '0;
      bus.sb_lsf_mdt_hits_freeze <= 1'b0;
      bus.sb_lsf_mdt_hits_re     <= 1'b0;
      bus.sb_lsf_mdt_hits_raddr  <= '0;
      bus.o_data                 <= '0;
      bus.o_valid                <= 1'b0;
      bus.o_last                 <= 1'b0;
      o_busy                     <= 1'b0;
      o_done                     <= 1'b0;
    end else begin
      bus.sb_lsf_mdt_hits_re <= 1'b0;
      o_done                 <= 1'b0;
      if (go_release) begin
        state_q                    <= RELEASE;
        bus.sb_lsf_mdt_hits_freeze <= 1'b0;
        bus.o_valid                <= 1'b0;
        bus.o_last                 <= 1'b0;
        o_done                     <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_start) begin
              addr_q                     <= i_start_addr;
              remaining_q                <= (i_num_words == '0) ? CNT_W'(DEPTH) : i_num_words;
              settle_q                   <= '0;
              bus.sb_lsf_mdt_hits_freeze <= 1'b1;
              o_busy                     <= 1'b1;
              if (FREEZE_SETTLE == 0) begin
                state_q                   <= READ;
                bus.sb_lsf_mdt_hits_re    <= 1'b1;
                bus.sb_lsf_mdt_hits_raddr <= i_start_addr;
              end else begin
                state_q <= SETTLE;
              end
            end
          end
          SETTLE: begin
            if (settle_q == SW'(FREEZE_SETTLE - 1)) begin
              state_q                   <= READ;
              bus.sb_lsf_mdt_hits_re    <= 1'b1;
              bus.sb_lsf_mdt_hits_raddr <= addr_q;
            end else begin
              settle_q <= settle_q + SW'(1);
            end
          end
          READ: state_q <= CAPTURE;
          // Spy data is valid exactly one cycle after the read strobe.
          CAPTURE: begin
            bus.o_data  <= bus.sb_lsf_mdt_hits_rdata;
            bus.o_valid <= 1'b1;
            bus.o_last  <= (remaining_q == CNT_W'(1));
            state_q     <= OUTPUT;
          end
          OUTPUT: begin
            if (i_ready_hs()) begin
              bus.o_valid               <= 1'b0;
              bus.o_last                <= 1'b0;
              addr_q                    <= addr_q + AW'(1);
              remaining_q               <= remaining_q - CNT_W'(1);
              state_q                   <= READ;
              bus.sb_lsf_mdt_hits_re    <= 1'b1;
              bus.sb_lsf_mdt_hits_raddr <= addr_q + AW'(1);
            end
          end
          RELEASE: begin
            state_q <= IDLE;
            o_busy  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsf_spy_readout.sv
// Directed bench for lsf_spy_readout: spy memory model plus per-readout scoreboard.
module tb_lsf_spy_readout;
  localparam int AW = 10;
  localparam int DW = 42;
  localparam int FS = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_start, i_abort;
  logic [AW-1:0] i_start_addr;
  logic [AW:0]   i_num_words;
  logic          o_busy, o_done;
  int            tests = 0;
  int            fails = 0;

  lsf_spy_readout_if #(.LSF_SB_MEM_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  lsf_spy_readout #(.LSF_SB_MEM_WIDTH(AW), .DATA_WIDTH(DW), .FREEZE_SETTLE(FS)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_start_addr (i_start_addr),
    .i_num_words  (i_num_words),
    .bus          (bus),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] spy_word(input logic [AW-1:0] a);
    return {a, 22'h15A5A5, a};
  endfunction

  // Spy memory: data only during the cycle after re, junk otherwise.
  always @(posedge clock)
    bus.sb_lsf_mdt_hits_rdata <= bus.sb_lsf_mdt_hits_re ? spy_word(bus.sb_lsf_mdt_hits_raddr) : '1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".freeze"}, bus.sb_lsf_mdt_hits_freeze, 0);
    check({tag, ".re"},     bus.sb_lsf_mdt_hits_re, 0);
    check({tag, ".raddr"},  bus.sb_lsf_mdt_hits_raddr, 0);
    check({tag, ".data"},   bus.o_data, 0);
    check({tag, ".valid"},  bus.o_valid, 0);
    check({tag, ".last"},   bus.o_last, 0);
    check({tag, ".busy"},   o_busy, 0);
    check({tag, ".done"},   o_done, 0);
  endtask

  task automatic run_readout(input string tag, input logic [AW-1:0] sa, input logic [AW:0] nw,
                             input int n_req, input int exp_words, input int exp_reads,
                             input int stall_word, input int abort_word,
                             input bit start_abort, input bit restart_mid);
    int   words = 0, reads = 0, stall = 0, first_re = -1, last_hs = -1;
    int   abort_cyc = -1, done_cyc = -1, dones = 0;
    int   addr_err = 0, data_err = 0, last_err = 0, freeze_err = 0;
    logic busy_after = 1'b1, valid_after = 1'b1;
    i_start_addr = sa;
    i_num_words  = nw;
    i_start      = 1'b1;
    i_abort      = start_abort;
    bus.i_ready  = 1'b1;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clock);
      i_start     = 1'b0;
      i_abort     = 1'b0;
      bus.i_ready = 1'b1;
      if (restart_mid && c == 2) begin
        i_start      = 1'b1;
        i_start_addr = ~sa;
      end
      if (done_cyc >= 0) begin
        if (c == done_cyc + 1) busy_after = o_busy;
        if (bus.sb_lsf_mdt_hits_re) reads++;
        if (o_done) dones++;
        if (c == done_cyc + 3) break;
        continue;
      end
      if (bus.sb_lsf_mdt_hits_re) begin
        if (first_re < 0) first_re = c;
        if (bus.sb_lsf_mdt_hits_raddr !== AW'(sa + reads)) addr_err++;
        reads++;
      end
      if (abort_cyc >= 0 && c == abort_cyc + 1) valid_after = bus.o_valid;
      if (o_done) begin
        dones++;
        done_cyc = c;
        if (bus.sb_lsf_mdt_hits_freeze !== 1'b0) freeze_err++;
      end else if (bus.sb_lsf_mdt_hits_freeze !== 1'b1) begin
        freeze_err++;
      end
      if (bus.o_valid && !o_done) begin
        if (bus.o_data !== spy_word(AW'(sa + words))) data_err++;
        if (bus.o_last !== (words == n_req - 1)) last_err++;
        if (words == stall_word && stall < 10) begin
          bus.i_ready = 1'b0;
          stall++;
        end else if (words == abort_word && abort_cyc < 0) begin
          i_abort   = 1'b1;
          abort_cyc = c;
        end else begin
          words++;
          last_hs = c;
        end
      end
    end
    check({tag, ".words"},      words, exp_words);
    check({tag, ".reads"},      reads, exp_reads);
    check({tag, ".dones"},      dones, 1);
    check({tag, ".first_re"},   first_re, FS + 1);
    check({tag, ".addr_err"},   addr_err, 0);
    check({tag, ".data_err"},   data_err, 0);
    check({tag, ".last_err"},   last_err, 0);
    check({tag, ".freeze_err"}, freeze_err, 0);
    check({tag, ".busy_after"}, busy_after, 0);
    check({tag, ".done_lat"},   done_cyc - ((abort_word >= 0) ? abort_cyc : last_hs), 1);
    if (abort_word >= 0) check({tag, ".valid_after_abort"}, valid_after, 0);
  endtask

  initial begin
    reset        = 1'b1;
    i_start      = 1'b0;
    i_abort      = 1'b0;
    i_start_addr = '0;
    i_num_words  = '0;
    bus.i_ready  = 1'b0;
    @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    run_readout("basic",   10'd5,    11'd3, 3, 3, 3, -1, -1, 1'b0, 1'b0);

    i_abort = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("idle_abort.busy",   o_busy, 0);
    check("idle_abort.freeze", bus.sb_lsf_mdt_hits_freeze, 0);
    check("idle_abort.done",   o_done, 0);
    i_abort = 1'b0;

    run_readout("wrap",      10'd1022, 11'd4, 4, 4, 4, -1, -1, 1'b0, 1'b0);
    run_readout("stall",     10'd100,  11'd5, 5, 5, 5,  1, -1, 1'b0, 1'b1);
    run_readout("abort",     10'd200,  11'd8, 8, 1, 2, -1,  1, 1'b0, 1'b0);
    run_readout("start_abt", 10'd50,   11'd2, 2, 2, 2, -1, -1, 1'b1, 1'b0);
    run_readout("full",      10'd7,    11'd0, 1024, 1024, 1024, -1, -1, 1'b0, 1'b0);

    i_start_addr = 10'd3;
    i_num_words  = 11'd2;
    i_start      = 1'b1;
    @(negedge clock);
    i_start = 1'b0;
    @(negedge clock);
    check("rst_mid.freeze_before", bus.sb_lsf_mdt_hits_freeze, 1);
    check("rst_mid.busy_before",   o_busy, 1);
    #2 reset = 1'b1;
    #1 check_all_zero("rst_mid");
    @(negedge clock);
    check("rst_mid.done_held", o_done, 0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid.busy_after", o_busy, 0);
    run_readout("after_rst", 10'd3, 11'd2, 2, 2, 2, -1, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
